// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the multiply/divide unit: operation encodings, the
//   control FSM state type and the op classification helpers. The helpers are
//   also used by the hazard unit to decide which ops occupy the unit.
// -----------------------------------------------------------------------------
package md_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MSUB  = 4'd7,
        MD_MSUBU = 4'd8,
        MD_MTHI  = 4'd9,
        MD_MTLO  = 4'd10
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Ops that compute a result through the shadow registers and hold busy.
    function automatic logic md_arith(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MSUBU);
    endfunction

    // Ops that use the divide latency.
    function automatic logic md_isdiv(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_latency_timer.sv
// -----------------------------------------------------------------------------
// md_latency_timer
//   Loadable down-counter that models the latency of an in-flight op.
//   Ports:
//     clk, reset  clock / asynchronous active-high reset
//     load        load lat into the counter (only issued while idle)
//     cancel      clear the counter, dominates load
//     lat         latency to load, >= 1
//     busy        counter non-zero
//     tc          counter equals 1: the next edge is the terminal edge
// -----------------------------------------------------------------------------
module md_latency_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          cancel,
    input  logic [CW-1:0] lat,
    output logic          busy,
    output logic          tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (cancel) begin
            count <= '0;
        end else if (load) begin
            count <= lat;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);
    assign tc   = (count == CW'(1));

endmodule

// File: rtl/muldiv_engine.sv
// -----------------------------------------------------------------------------
// muldiv_engine
//   Multiply/divide unit with HI/LO registers for the EX stage. The full
//   2*WIDTH result is computed combinationally at accept, parked in a shadow
//   register, and committed to {hi,lo} when the latency timer expires.
//   Ports:
//     clk, reset  clock / asynchronous active-high reset
//     start       issue op this cycle; accepted only when idle and not cancelled
//     op          operation code (md_op_e)
//     a, b        rs / rt operands
//     cancel      abort the in-flight op; hi/lo keep their pre-op values
//     busy        op in flight
//     done        one-cycle pulse on the cycle hi/lo took a new result
//     hi, lo      HI / LO registers
// -----------------------------------------------------------------------------
module muldiv_engine import md_pkg::*; #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam int W2      = 2 * WIDTH;

    // Divide result packed as {remainder, quotient}. Zero divisor and the
    // MIN / -1 overflow have fixed results instead of trapping.
    function automatic logic [W2-1:0] div_result(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             is_signed);
        logic [WIDTH-1:0]        min_val;
        logic [WIDTH-1:0]        y_nz;
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        logic signed [WIDTH-1:0] q_s;
        logic signed [WIDTH-1:0] r_s;
        logic [W2-1:0]           res;
        min_val = {1'b1, {(WIDTH-1){1'b0}}};
        // Divisor forced non-zero so the divider never sees 0.
        y_nz    = (y == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : y;
        sx      = $signed(x);
        sy      = $signed(y_nz);
        q_s     = sx / sy;
        r_s     = sx % sy;
        if (y == '0) begin
            res = {x, {WIDTH{1'b1}}};
        end else if (is_signed && (x == min_val) && (y == {WIDTH{1'b1}})) begin
            res = {{WIDTH{1'b0}}, min_val};
        end else if (is_signed) begin
            res = {r_s, q_s};
        end else begin
            res = {x % y_nz, x / y_nz};
        end
        return res;
    endfunction

    md_state_e         state;
    logic [W2-1:0]     shadow;
    logic [W2-1:0]     result;
    logic [W2-1:0]     acc;
    logic signed [W2-1:0] prod_s;
    logic [W2-1:0]     prod_u;
    logic [CW-1:0]     lat_sel;
    logic              accept;
    logic              load;
    logic              commit;
    logic              tc;

    assign acc    = {hi, lo};
    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        result = '0;
        case (op)
            MD_MULT:  result = $unsigned(prod_s);
            MD_MULTU: result = prod_u;
            MD_DIV:   result = div_result(a, b, 1'b1);
            MD_DIVU:  result = div_result(a, b, 1'b0);
            MD_MADD:  result = acc + $unsigned(prod_s);
            MD_MADDU: result = acc + prod_u;
            MD_MSUB:  result = acc - $unsigned(prod_s);
            MD_MSUBU: result = acc - prod_u;
            default:  result = '0;
        endcase
    end

    // cancel blocks acceptance even when the unit is idle.
    assign accept  = start & ~busy & ~cancel;
    assign load    = accept & md_arith(op);
    assign lat_sel = md_isdiv(op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
    // cancel dominates a commit landing on the same edge.
    assign commit  = (state == MD_RUN) & tc & ~cancel;

    md_latency_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .cancel (cancel),
        .lat    (lat_sel),
        .busy   (busy),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= MD_IDLE;
            shadow <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= commit;
            case (state)
                MD_IDLE: begin
                    if (load) begin
                        shadow <= result;
                        state  <= MD_RUN;
                    end else if (accept && (op == MD_MTHI)) begin
                        hi <= a;
                    end else if (accept && (op == MD_MTLO)) begin
                        lo <= a;
                    end
                end
                MD_RUN: begin
                    if (cancel) begin
                        state <= MD_IDLE;
                    end else if (tc) begin
                        {hi, lo} <= shadow;
                        state    <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_engine.sv
// -----------------------------------------------------------------------------
// tb_muldiv_engine
//   Directed testbench for muldiv_engine (WIDTH=32, MULT_LAT=5, DIV_LAT=10).
// -----------------------------------------------------------------------------
module tb_muldiv_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_engine #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = 4'd0;
        a     = '0;
        b     = '0;
    endtask

    // Count remaining busy cycles and done pulses until the unit goes idle.
    task automatic wait_idle(output int cyc, output int dn);
        cyc = 0;
        dn  = 0;
        while (busy === 1'b1 && cyc < 100) begin
            tick();
            cyc++;
            if (done === 1'b1) dn++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: sim time %0t, limit reached", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int dn;
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 4'd0;
        a      = '0;
        b      = '0;
        tick();
        tick();
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // MULT -3 * 7
        issue(4'd1, 32'hFFFF_FFFD, 32'd7);
        check("mult_busy", busy, 1);
        check("mult_hi_hold", hi, 0);
        wait_idle(cyc, dn);
        check("mult_cycles", cyc, 5);
        check("mult_done", done, 1);
        check("mult_done_cnt", dn, 1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);
        tick();
        check("mult_done_pulse", done, 0);

        // MULTU then back-to-back MADDU
        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_idle(cyc, dn);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        issue(4'd6, 32'd1, 32'd2);
        check("b2b_busy", busy, 1);
        check("b2b_done_low", done, 0);
        wait_idle(cyc, dn);
        check("maddu_lo", lo, 32'h0000_0000);
        check("maddu_hi", hi, 32'h0000_0002);

        // DIV -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc, dn);
        check("div_cycles", cyc, 10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero
        issue(4'd4, 32'd5, 32'd0);
        wait_idle(cyc, dn);
        check("divz_cycles", cyc, 10);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'd5);

        // DIV overflow with starts issued while busy
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        start = 1'b1; op = 4'd10; a = 32'hDEAD;
        tick();
        start = 1'b1; op = 4'd1; a = 32'd2; b = 32'd2;
        tick();
        start = 1'b0; op = 4'd0; a = '0; b = '0;
        check("ign_lo", lo, 32'hFFFF_FFFF);
        check("ign_hi", hi, 32'd5);
        wait_idle(cyc, dn);
        check("ovf_cycles", cyc, 7);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);
        tick();
        check("ovf_no_restart", busy, 0);

        // MTHI / MTLO then cancelled MULT
        issue(4'd9, 32'h11, 32'd0);
        check("mthi_hi", hi, 32'h11);
        check("mthi_busy", busy, 0);
        check("mthi_done", done, 0);
        issue(4'd10, 32'h11, 32'd0);
        check("mtlo_lo", lo, 32'h11);
        issue(4'd1, 32'd4, 32'd4);
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cxl_busy", busy, 0);
        check("cxl_done", done, 0);
        check("cxl_hi", hi, 32'h11);
        check("cxl_lo", lo, 32'h11);
        dn = 0;
        repeat (6) begin
            tick();
            if (done === 1'b1) dn++;
        end
        check("cxl_no_done", dn, 0);

        // cancel on the commit edge
        issue(4'd1, 32'd4, 32'd4);
        repeat (4) tick();
        check("cc_busy_last", busy, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cc_busy", busy, 0);
        check("cc_done", done, 0);
        check("cc_lo", lo, 32'h11);

        // cancel with start while idle
        cancel = 1'b1; start = 1'b1; op = 4'd10; a = 32'h99;
        tick();
        check("cs_mtlo_lo", lo, 32'h11);
        op = 4'd1; a = 32'd3; b = 32'd3;
        tick();
        cancel = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;
        check("cs_mult_busy", busy, 0);

        // undefined op is a NOP
        issue(4'd12, 32'd3, 32'd3);
        check("nop_busy", busy, 0);
        check("nop_hi", hi, 32'h11);

        // reset mid-DIV
        issue(4'd3, 32'd100, 32'd3);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", busy, 0);
        tick();
        reset = 1'b0;
        tick();
        check("arst_stay_idle", busy, 0);

        // MTLO when idle
        issue(4'd10, 32'h1234, 32'd0);
        check("mtlo2_lo", lo, 32'h1234);
        check("mtlo2_busy", busy, 0);
        tick();
        check("mtlo2_done", done, 0);

        // MSUB / MADD / MSUBU accumulate chain
        issue(4'd7, 32'd2, 32'd3);
        wait_idle(cyc, dn);
        check("msub1_lo", lo, 32'h0000_122E);
        check("msub1_hi", hi, 32'h0);
        issue(4'd7, 32'h1000, 32'd2);
        wait_idle(cyc, dn);
        check("msub2_lo", lo, 32'hFFFF_F22E);
        check("msub2_hi", hi, 32'hFFFF_FFFF);
        issue(4'd5, 32'hFFFF_FFFF, 32'd1);
        wait_idle(cyc, dn);
        check("madd_lo", lo, 32'hFFFF_F22D);
        check("madd_hi", hi, 32'hFFFF_FFFF);
        issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(cyc, dn);
        check("msubu_cycles", cyc, 5);
        check("msubu_lo", lo, 32'hFFFF_F22C);
        check("msubu_hi", hi, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
